// File: rtl/quad_spinner_decoder.sv
// quad_spinner_decoder: AB quadrature receiver for spinners and encoders.
// Synchronises and deglitches the raw phases, decodes legal Gray steps and gates them by
// the selected resolution. Counted steps are accumulated into a saturating signed
// counter. At the end of each report window a clamped 8-bit delta is emitted with a
// toggle strobe, and any remainder carries into the next window.
// Optional build macro: QUAD_POS_EN adds a 16-bit wrapping absolute position output.
module quad_spinner_decoder #(
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned REPORT_DIV = 48000,
    parameter int unsigned CNT_W      = 12
) (
    input  logic        clk_12m,
    input  logic        reset,
    input  logic        ce,
    input  logic        enc_a,
    input  logic        enc_b,
    input  logic [1:0]  div_mode,
    output logic [7:0]  delta,
    output logic        report_toggle,
    output logic        step_stb,
    output logic        step_dir,
`ifdef QUAD_POS_EN
    output logic [15:0] pos,
`endif
    output logic [7:0]  illegal_cnt
);

    localparam int unsigned TMR_W  = (REPORT_DIV > 1) ? $clog2(REPORT_DIV) : 1;
    localparam int unsigned WIDE_W = CNT_W + 2;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REPORT_DIV - 1);
    localparam logic [3:0]       FLT_LAST = 4'(FILTER_LEN - 1);

    localparam logic signed [CNT_W-1:0] ACC_MAX  = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W-1:0] ACC_MIN  = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic signed [CNT_W-1:0] CLAMP_HI = CNT_W'(127);
    localparam logic signed [CNT_W-1:0] CLAMP_LO = CNT_W'(-128);

    localparam logic signed [WIDE_W-1:0] ACC_MAX_W = $signed({2'b00, ACC_MAX});
    localparam logic signed [WIDE_W-1:0] ACC_MIN_W = $signed({2'b11, ACC_MIN});

    // ------------------------------------------------------------------------------------
    // Synchroniser and filter state
    // ------------------------------------------------------------------------------------
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] stable_q;
    logic [1:0] stable_d;
    logic [3:0] flt_cnt_q;
    logic [3:0] flt_cnt_d;
    logic       upd;

    // Decode stage: registered event flags, one cycle after the stable update
    logic       evt_cnt_d;
    logic       evt_cnt_q;
    logic       evt_dir_d;
    logic       evt_dir_q;
    logic       evt_ill_d;
    logic       evt_ill_q;

    // Output stage
    logic                    step_stb_q;
    logic                    step_dir_q;
    logic [7:0]              illegal_cnt_q;
    logic [7:0]              illegal_cnt_d;
    logic signed [CNT_W-1:0] acc_q;
    logic signed [CNT_W-1:0] acc_d;
    logic [TMR_W-1:0]        timer_q;
    logic [TMR_W-1:0]        timer_d;
    logic [7:0]              delta_q;
    logic [7:0]              delta_d;
    logic                    toggle_q;
    logic                    toggle_d;

    // Report arithmetic
    logic                     wrap;
    logic                     report;
    logic signed [7:0]        delta_rep;
    logic signed [WIDE_W-1:0] acc_w;
    logic signed [WIDE_W-1:0] rep_w;
    logic signed [WIDE_W-1:0] step_w;
    logic signed [WIDE_W-1:0] sum_w;

    // Two-flop synchroniser on both raw phases; runs every clock, independent of ce
    always_ff @(posedge clk_12m or posedge reset) begin
        if (reset) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
        end else begin
            sync1_q <= {enc_a, enc_b};
            sync2_q <= sync1_q;
        end
    end

    // Glitch filter: a new AB value must disagree with the stable value for FILTER_LEN
    // consecutive ce ticks. Comparing against the stable value (not the last sample)
    // means any bounce back to the stable value restarts the count.
    always_comb begin
        stable_d  = stable_q;
        flt_cnt_d = flt_cnt_q;
        upd       = 1'b0;
        if (ce) begin
            if (sync2_q != stable_q) begin
                if (flt_cnt_q >= FLT_LAST) begin
                    stable_d  = sync2_q;
                    flt_cnt_d = 4'd0;
                    upd       = 1'b1;
                end else begin
                    flt_cnt_d = flt_cnt_q + 4'd1;
                end
            end else begin
                flt_cnt_d = 4'd0;
            end
        end
    end

    // Filter state registers
    always_ff @(posedge clk_12m or posedge reset) begin
        if (reset) begin
            stable_q  <= 2'b11;
            flt_cnt_q <= 4'd0;
        end else begin
            stable_q  <= stable_d;
            flt_cnt_q <= flt_cnt_d;
        end
    end

    // Transition decode. Mapping AB to a Gray index {A, A^B} turns the forward sequence
    // 00->01->11->10 into 0->1->2->3, so the index difference gives the direction:
    // +1 forward, -1 (3) reverse, 2 means both bits moved (illegal).
    always_comb begin
        logic [1:0] idx_old;
        logic [1:0] idx_new;
        logic [1:0] idx_diff;
        logic       fwd;
        logic       rev;
        logic       gate;

        idx_old  = {stable_q[1], stable_q[1] ^ stable_q[0]};
        idx_new  = {stable_d[1], stable_d[1] ^ stable_d[0]};
        idx_diff = idx_new - idx_old;
        fwd      = (idx_diff == 2'd1);
        rev      = (idx_diff == 2'd3);

        // Resolution gating looks at the state being arrived at
        case (div_mode)
            2'd0:    gate = 1'b1;
            2'd1:    gate = (stable_d == 2'b00) || (stable_d == 2'b11);
            default: gate = (stable_d == 2'b00);
        endcase

        evt_cnt_d = upd && (fwd || rev) && gate;
        evt_dir_d = fwd;
        evt_ill_d = upd && (idx_diff == 2'd2);
    end

    // Event flags are single-cycle pulses
    always_ff @(posedge clk_12m or posedge reset) begin
        if (reset) begin
            evt_cnt_q <= 1'b0;
            evt_dir_q <= 1'b0;
            evt_ill_q <= 1'b0;
        end else begin
            evt_cnt_q <= evt_cnt_d;
            evt_dir_q <= evt_dir_d;
            evt_ill_q <= evt_ill_d;
        end
    end

    // Report window timer and accumulator next-state. A report and a step in the same
    // cycle are combined so the step always survives into the remainder.
    always_comb begin
        timer_d  = timer_q;
        wrap     = 1'b0;
        if (ce) begin
            if (timer_q == TMR_LAST) begin
                timer_d = '0;
                wrap    = 1'b1;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end

        report = wrap && (acc_q != '0);

        if (acc_q > CLAMP_HI) begin
            delta_rep = 8'sh7F;
        end else if (acc_q < CLAMP_LO) begin
            delta_rep = 8'sh80;
        end else begin
            delta_rep = acc_q[7:0];
        end

        acc_w = $signed({{2{acc_q[CNT_W-1]}}, acc_q});

        rep_w = '0;
        if (report) begin
            rep_w = $signed({{(WIDE_W-8){delta_rep[7]}}, delta_rep});
        end

        step_w = '0;
        if (evt_cnt_q) begin
            step_w = evt_dir_q ? WIDE_W'(1) : '1;
        end

        sum_w = acc_w - rep_w + step_w;

        if (sum_w > ACC_MAX_W) begin
            acc_d = ACC_MAX;
        end else if (sum_w < ACC_MIN_W) begin
            acc_d = ACC_MIN;
        end else begin
            acc_d = sum_w[CNT_W-1:0];
        end

        delta_d  = delta_q;
        toggle_d = toggle_q;
        if (report) begin
            delta_d  = delta_rep;
            toggle_d = ~toggle_q;
        end

        illegal_cnt_d = illegal_cnt_q;
        if (evt_ill_q && (illegal_cnt_q != 8'hFF)) begin
            illegal_cnt_d = illegal_cnt_q + 8'd1;
        end
    end

    // Step strobe, direction, counters and report outputs
    always_ff @(posedge clk_12m or posedge reset) begin
        if (reset) begin
            step_stb_q    <= 1'b0;
            step_dir_q    <= 1'b0;
            illegal_cnt_q <= 8'd0;
            acc_q         <= '0;
            timer_q       <= '0;
            delta_q       <= 8'd0;
            toggle_q      <= 1'b0;
        end else begin
            step_stb_q    <= evt_cnt_q;
            if (evt_cnt_q) begin
                step_dir_q <= evt_dir_q;
            end
            illegal_cnt_q <= illegal_cnt_d;
            acc_q         <= acc_d;
            timer_q       <= timer_d;
            delta_q       <= delta_d;
            toggle_q      <= toggle_d;
        end
    end

`ifdef QUAD_POS_EN
    logic [15:0] pos_q;

    // Absolute position follows counted steps only and wraps freely
    always_ff @(posedge clk_12m or posedge reset) begin
        if (reset) begin
            pos_q <= 16'd0;
        end else if (evt_cnt_q) begin
            pos_q <= evt_dir_q ? pos_q + 16'd1 : pos_q - 16'd1;
        end
    end

    assign pos = pos_q;
`endif

    assign delta         = delta_q;
    assign report_toggle = toggle_q;
    assign step_stb      = step_stb_q;
    assign step_dir      = step_dir_q;
    assign illegal_cnt   = illegal_cnt_q;

endmodule

// File: tb/tb_quad_spinner_decoder.sv
// Directed bench for quad_spinner_decoder. Instance a uses a 64-tick report window,
// instance b a 4096-tick window for the long burst. Both run with ce held high.
module tb_quad_spinner_decoder;

    logic       clk_12m = 1'b0;
    logic       reset   = 1'b1;
    logic       ce      = 1'b1;
    logic       a_enc_a = 1'b1;
    logic       a_enc_b = 1'b1;
    logic       b_enc_a = 1'b1;
    logic       b_enc_b = 1'b1;
    logic [1:0] a_mode  = 2'd0;
    logic [1:0] b_mode  = 2'd0;

    logic [7:0] a_delta;
    logic       a_tog;
    logic       a_stb;
    logic       a_dir;
    logic [7:0] a_ill;
    logic [7:0] b_delta;
    logic       b_tog;
    logic       b_stb;
    logic       b_dir;
    logic [7:0] b_ill;

    int pass_n  = 0;
    int total_n = 0;
    int cyc;
    int a_stb_n = 0;
    int a_tog_n = 0;
    int b_stb_n = 0;
    int b_tog_n = 0;
    logic a_tog_prev = 1'b0;
    logic b_tog_prev = 1'b0;

    quad_spinner_decoder #(
        .FILTER_LEN(4),
        .REPORT_DIV(64),
        .CNT_W(12)
    ) dut_a (
        .clk_12m      (clk_12m),
        .reset        (reset),
        .ce           (ce),
        .enc_a        (a_enc_a),
        .enc_b        (a_enc_b),
        .div_mode     (a_mode),
        .delta        (a_delta),
        .report_toggle(a_tog),
        .step_stb     (a_stb),
        .step_dir     (a_dir),
        .illegal_cnt  (a_ill)
    );

    quad_spinner_decoder #(
        .FILTER_LEN(4),
        .REPORT_DIV(4096),
        .CNT_W(12)
    ) dut_b (
        .clk_12m      (clk_12m),
        .reset        (reset),
        .ce           (ce),
        .enc_a        (b_enc_a),
        .enc_b        (b_enc_b),
        .div_mode     (b_mode),
        .delta        (b_delta),
        .report_toggle(b_tog),
        .step_stb     (b_stb),
        .step_dir     (b_dir),
        .illegal_cnt  (b_ill)
    );

    always #5 clk_12m = ~clk_12m;

    // Free-running cycle count since reset release; phase within a window is cyc % DIV
    always @(posedge clk_12m or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Count strobe pulses and toggle edges away from the active edge
    always @(negedge clk_12m) begin
        if (a_stb === 1'b1) a_stb_n++;
        if (b_stb === 1'b1) b_stb_n++;
        if (a_tog !== a_tog_prev) a_tog_n++;
        if (b_tog !== b_tog_prev) b_tog_n++;
        a_tog_prev = a_tog;
        b_tog_prev = b_tog;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_12m);
            #1;
        end
    endtask

    task automatic wait_phase_a(input int ph);
        while ((cyc % 64) != ph) tick(1);
    endtask

    task automatic wait_phase_b(input int ph);
        while ((cyc % 4096) != ph) tick(1);
    endtask

    task automatic drive_a(input logic [1:0] ab, input int hold);
        {a_enc_a, a_enc_b} = ab;
        tick(hold);
    endtask

    task automatic test_reset();
        int s;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        s = a_stb_n;
        tick(200);
        total_n++;
        if (a_delta !== 8'd0) $display("FAIL reset_delta: got %0h want 0", a_delta);
        else pass_n++;
        total_n++;
        if (a_tog !== 1'b0) $display("FAIL reset_toggle: got %0b want 0", a_tog);
        else pass_n++;
        total_n++;
        if (a_stb !== 1'b0) $display("FAIL reset_stb: got %0b want 0", a_stb);
        else pass_n++;
        total_n++;
        if (a_dir !== 1'b0) $display("FAIL reset_dir: got %0b want 0", a_dir);
        else pass_n++;
        total_n++;
        if (a_ill !== 8'd0) $display("FAIL reset_illegal: got %0d want 0", a_ill);
        else pass_n++;
        total_n++;
        if (a_stb_n != s) $display("FAIL reset_no_steps: got %0d pulses want 0", a_stb_n - s);
        else pass_n++;
        total_n++;
        if (b_stb_n != 0 || b_tog_n != 0)
            $display("FAIL reset_b_idle: got %0d pulses %0d toggles want 0 0", b_stb_n, b_tog_n);
        else pass_n++;
    endtask

    task automatic test_fwd_x4();
        logic [1:0] seq [7] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11};
        int s;
        int t;
        a_mode = 2'd0;
        wait_phase_a(1);
        s = a_stb_n;
        t = a_tog_n;
        // First step also measures latency: strobe appears 7 cycles after the edge
        {a_enc_a, a_enc_b} = 2'b10;
        tick(6);
        total_n++;
        if (a_stb !== 1'b0) $display("FAIL latency_early: got %0b want 0", a_stb);
        else pass_n++;
        tick(1);
        total_n++;
        if (a_stb !== 1'b1) $display("FAIL latency_stb: got %0b want 1", a_stb);
        else pass_n++;
        tick(1);
        for (int i = 0; i < 7; i++) drive_a(seq[i], 6);
        tick(4);
        total_n++;
        if (a_stb_n - s != 8) $display("FAIL fwd_steps: got %0d want 8", a_stb_n - s);
        else pass_n++;
        total_n++;
        if (a_dir !== 1'b1) $display("FAIL fwd_dir: got %0b want 1", a_dir);
        else pass_n++;
        total_n++;
        if (a_tog_n != t) $display("FAIL fwd_early_report: got %0d toggles want 0", a_tog_n - t);
        else pass_n++;
        wait_phase_a(2);
        total_n++;
        if (a_delta !== 8'd8 || a_tog !== 1'b1)
            $display("FAIL fwd_report: got delta %0h toggle %0b want 08 1", a_delta, a_tog);
        else pass_n++;
        t = a_tog_n;
        tick(64);
        total_n++;
        if (a_tog_n != t || a_delta !== 8'd8)
            $display("FAIL fwd_idle_window: got %0d toggles delta %0h want 0 08",
                     a_tog_n - t, a_delta);
        else pass_n++;
    endtask

    task automatic test_rev_x1();
        logic [1:0] seq [8] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11};
        int s;
        a_mode = 2'd2;
        wait_phase_a(1);
        s = a_stb_n;
        for (int i = 0; i < 8; i++) drive_a(seq[i], 6);
        tick(4);
        total_n++;
        if (a_stb_n - s != 2) $display("FAIL rev_x1_steps: got %0d want 2", a_stb_n - s);
        else pass_n++;
        total_n++;
        if (a_dir !== 1'b0) $display("FAIL rev_x1_dir: got %0b want 0", a_dir);
        else pass_n++;
        wait_phase_a(2);
        total_n++;
        if (a_delta !== 8'hFE) $display("FAIL rev_x1_delta: got %0h want fe", a_delta);
        else pass_n++;
        total_n++;
        if (a_tog !== 1'b0) $display("FAIL rev_x1_toggle: got %0b want 0", a_tog);
        else pass_n++;
    endtask

    task automatic test_glitch_illegal();
        int s;
        int t;
        a_mode = 2'd0;
        wait_phase_a(1);
        s = a_stb_n;
        t = a_tog_n;
        drive_a(2'b10, 2);
        drive_a(2'b11, 20);
        total_n++;
        if (a_stb_n != s) $display("FAIL glitch_steps: got %0d want 0", a_stb_n - s);
        else pass_n++;
        drive_a(2'b00, 10);
        total_n++;
        if (a_ill !== 8'd1) $display("FAIL illegal_first: got %0d want 1", a_ill);
        else pass_n++;
        total_n++;
        if (a_stb_n != s) $display("FAIL illegal_steps: got %0d want 0", a_stb_n - s);
        else pass_n++;
        drive_a(2'b11, 10);
        total_n++;
        if (a_ill !== 8'd2) $display("FAIL illegal_second: got %0d want 2", a_ill);
        else pass_n++;
        wait_phase_a(2);
        total_n++;
        if (a_tog_n != t) $display("FAIL glitch_report: got %0d toggles want 0", a_tog_n - t);
        else pass_n++;
        total_n++;
        if (a_delta !== 8'hFE) $display("FAIL glitch_delta: got %0h want fe", a_delta);
        else pass_n++;
    endtask

    task automatic test_step_on_report();
        logic [1:0] seq [5] = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b10};
        int t;
        a_mode = 2'd0;
        wait_phase_a(1);
        for (int i = 0; i < 5; i++) drive_a(seq[i], 6);
        // Edge at phase 57 reaches the accumulator exactly on the wrap cycle
        wait_phase_a(57);
        t = a_tog_n;
        {a_enc_a, a_enc_b} = 2'b00;
        wait_phase_a(1);
        total_n++;
        if (a_delta !== 8'd5) $display("FAIL coincide_delta: got %0h want 05", a_delta);
        else pass_n++;
        total_n++;
        if (a_tog_n != t + 1) $display("FAIL coincide_toggle: got %0d want 1", a_tog_n - t);
        else pass_n++;
        tick(1);
        wait_phase_a(1);
        total_n++;
        if (a_delta !== 8'd1) $display("FAIL remainder_delta: got %0h want 01", a_delta);
        else pass_n++;
        total_n++;
        if (a_tog_n != t + 2) $display("FAIL remainder_toggle: got %0d want 2", a_tog_n - t);
        else pass_n++;
        tick(64);
        total_n++;
        if (a_tog_n != t + 2) $display("FAIL remainder_quiet: got %0d want 2", a_tog_n - t);
        else pass_n++;
    endtask

    task automatic test_burst_clamp();
        logic [1:0] order [4] = '{2'b10, 2'b00, 2'b01, 2'b11};
        logic [7:0] want_d [4] = '{8'h7F, 8'h7F, 8'h2E, 8'h2E};
        int want_t [4] = '{1, 2, 3, 3};
        int s;
        b_mode = 2'd0;
        wait_phase_b(1);
        s = b_stb_n;
        for (int i = 0; i < 300; i++) begin
            {b_enc_a, b_enc_b} = order[i % 4];
            tick(6);
        end
        tick(10);
        total_n++;
        if (b_stb_n - s != 300) $display("FAIL burst_steps: got %0d want 300", b_stb_n - s);
        else pass_n++;
        total_n++;
        if (b_dir !== 1'b1 || b_tog_n != 0)
            $display("FAIL burst_pre_report: got dir %0b toggles %0d want 1 0", b_dir, b_tog_n);
        else pass_n++;
        for (int w = 0; w < 4; w++) begin
            tick(1);
            wait_phase_b(2);
            total_n++;
            if (b_delta !== want_d[w] || b_tog_n != want_t[w])
                $display("FAIL burst_report_%0d: got delta %0h toggles %0d want %0h %0d",
                         w, b_delta, b_tog_n, want_d[w], want_t[w]);
            else pass_n++;
        end
    endtask

    initial begin
        test_reset();
        test_fwd_x4();
        test_rev_x1();
        test_glitch_illegal();
        test_step_on_report();
        test_burst_clamp();
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
